// File: rtl/pmem_arbiter_if.sv
// Bundle of the icache, dcache and downstream line-memory ports seen by pmem_arbiter.
// slave: the arbiter's view. master: the environment (caches and memory) driving it.
interface pmem_arbiter_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int LINE_WIDTH = 256
);
  logic                  i_pmem_read;
  logic [ADDR_WIDTH-1:0] i_pmem_address;
  logic [LINE_WIDTH-1:0] i_pmem_rdata;
  logic                  i_pmem_resp;

  logic                  d_pmem_read;
  logic                  d_pmem_write;
  logic [ADDR_WIDTH-1:0] d_pmem_address;
  logic [LINE_WIDTH-1:0] d_pmem_wdata;
  logic [LINE_WIDTH-1:0] d_pmem_rdata;
  logic                  d_pmem_resp;

  logic                  pmem_read;
  logic                  pmem_write;
  logic [ADDR_WIDTH-1:0] pmem_address;
  logic [LINE_WIDTH-1:0] pmem_wdata;
  logic [LINE_WIDTH-1:0] pmem_rdata;
  logic                  pmem_resp;

  modport slave (
    input  i_pmem_read, i_pmem_address,
    output i_pmem_rdata, i_pmem_resp,
    input  d_pmem_read, d_pmem_write, d_pmem_address, d_pmem_wdata,
    output d_pmem_rdata, d_pmem_resp,
    output pmem_read, pmem_write, pmem_address, pmem_wdata,
    input  pmem_rdata, pmem_resp
  );

  modport master (
    output i_pmem_read, i_pmem_address,
    input  i_pmem_rdata, i_pmem_resp,
    output d_pmem_read, d_pmem_write, d_pmem_address, d_pmem_wdata,
    input  d_pmem_rdata, d_pmem_resp,
    input  pmem_read, pmem_write, pmem_address, pmem_wdata,
    output pmem_rdata, pmem_resp
  );
endinterface

// File: rtl/pmem_arbiter.sv
// Shares one line-wide memory port between icache and dcache, one transaction at a time.
// Define PMEM_ARB_ROUND_ROBIN_EN for round-robin ties instead of dcache priority with a streak limit.
module pmem_arbiter #(
  parameter int ADDR_WIDTH   = 32,
  parameter int LINE_WIDTH   = 256,
  parameter int MAX_D_STREAK = 4
) (
  input  logic              clk,
  input  logic              rst,
  pmem_arbiter_if.slave     bus,
  output logic              arb_error
);

  typedef enum logic [1:0] {IDLE, SERVE_I, SERVE_D} state_t;

  state_t state_reg, state_next;
  logic   i_req, d_req, tie_to_d;
  logic   grant_i, grant_d;
  logic   arb_error_reg;

  assign i_req   = bus.i_pmem_read;
  assign d_req   = bus.d_pmem_read | bus.d_pmem_write;
  assign grant_i = (state_reg == IDLE) && (state_next == SERVE_I);
  assign grant_d = (state_reg == IDLE) && (state_next == SERVE_D);

`ifdef PMEM_ARB_ROUND_ROBIN_EN
  // Remembers who was granted most recently; a tie goes to the other side.
  logic last_grant_d_reg;

  assign tie_to_d = ~last_grant_d_reg;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      last_grant_d_reg <= 1'b0;
    else if (grant_i || grant_d)
      last_grant_d_reg <= grant_d;
  end
`else
  localparam int                  STREAK_W   = $clog2(MAX_D_STREAK + 1);
  localparam logic [STREAK_W-1:0] STREAK_MAX = STREAK_W'(MAX_D_STREAK);

  // Counts dcache grants won while the icache was left waiting.
  logic [STREAK_W-1:0] d_streak_reg;

  assign tie_to_d = (d_streak_reg != STREAK_MAX);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      d_streak_reg <= '0;
    else if (grant_i)
      d_streak_reg <= '0;
    else if (grant_d && i_req && (d_streak_reg != STREAK_MAX))
      d_streak_reg <= d_streak_reg + STREAK_W'(1);
  end
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      state_reg <= IDLE;
    else
      state_reg <= state_next;
  end

  always_comb begin
    state_next       = state_reg;
    bus.pmem_read    = 1'b0;
    bus.pmem_write   = 1'b0;
    bus.pmem_address = {ADDR_WIDTH{1'b0}};
    bus.pmem_wdata   = {LINE_WIDTH{1'b0}};
    bus.i_pmem_resp  = 1'b0;
    bus.i_pmem_rdata = {LINE_WIDTH{1'b0}};
    bus.d_pmem_resp  = 1'b0;
    bus.d_pmem_rdata = {LINE_WIDTH{1'b0}};
    case (state_reg)
      IDLE: begin
        if (i_req && d_req)
          state_next = tie_to_d ? SERVE_D : SERVE_I;
        else if (d_req)
          state_next = SERVE_D;
        else if (i_req)
          state_next = SERVE_I;
      end
      SERVE_I: begin
        bus.pmem_read    = bus.i_pmem_read;
        bus.pmem_address = bus.i_pmem_address;
        bus.i_pmem_resp  = bus.pmem_resp;
        bus.i_pmem_rdata = bus.pmem_rdata;
        if (bus.pmem_resp)
          state_next = IDLE;
      end
      SERVE_D: begin
        // A simultaneous read+write is treated as a writeback.
        bus.pmem_read    = bus.d_pmem_read & ~bus.d_pmem_write;
        bus.pmem_write   = bus.d_pmem_write;
        bus.pmem_address = bus.d_pmem_address;
        bus.pmem_wdata   = bus.d_pmem_wdata;
        bus.d_pmem_resp  = bus.pmem_resp;
        bus.d_pmem_rdata = bus.pmem_rdata;
        if (bus.pmem_resp)
          state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      arb_error_reg <= 1'b0;
    else if ((state_reg == SERVE_D) && bus.d_pmem_read && bus.d_pmem_write)
      arb_error_reg <= 1'b1;
  end

  assign arb_error = arb_error_reg;

endmodule

// File: tb/tb_pmem_arbiter.sv
// Self-checking bench for pmem_arbiter: directed scenarios plus a randomized run
// against a transaction-level grant model.
module tb_pmem_arbiter;
  localparam int AW    = 32;
  localparam int LW    = 256;
  localparam int MAX_D = 2;

  logic clk = 1'b0;
  logic rst;
  logic arb_error;
  int   checks   = 0;
  int   failures = 0;

  pmem_arbiter_if #(.ADDR_WIDTH(AW), .LINE_WIDTH(LW)) bus ();

  pmem_arbiter #(.ADDR_WIDTH(AW), .LINE_WIDTH(LW), .MAX_D_STREAK(MAX_D)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .arb_error (arb_error)
  );

  always #5 clk = ~clk;

  function automatic int out_ones();
    return $countones({bus.pmem_read, bus.pmem_write, bus.pmem_address, bus.pmem_wdata,
                       bus.i_pmem_resp, bus.i_pmem_rdata, bus.d_pmem_resp, bus.d_pmem_rdata});
  endfunction

  function automatic logic [LW-1:0] rand_line();
    return {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom} | 1;
  endfunction

  task automatic idle_inputs();
    bus.i_pmem_read    = 1'b0;
    bus.i_pmem_address = '0;
    bus.d_pmem_read    = 1'b0;
    bus.d_pmem_write   = 1'b0;
    bus.d_pmem_address = '0;
    bus.d_pmem_wdata   = '0;
    bus.pmem_resp      = 1'b0;
    bus.pmem_rdata     = '0;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    idle_inputs();
    bus.i_pmem_read   = 1'b1;
    bus.d_pmem_write  = 1'b1;
    bus.pmem_resp     = 1'b1;
    bus.pmem_rdata    = rand_line();
    repeat (3) @(negedge clk);
    #1;
    checks++;
    if (out_ones() !== 0) begin
      failures++;
      $display("FAIL reset_outputs got %0d set bits, want 0", out_ones());
    end
    checks++;
    if (arb_error !== 1'b0) begin
      failures++;
      $display("FAIL reset_arb_error got %b want 0", arb_error);
    end
    idle_inputs();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    #1;
    checks++;
    if (bus.pmem_read !== 1'b0 || bus.pmem_write !== 1'b0) begin
      failures++;
      $display("FAIL post_reset_idle got r=%b w=%b want 0 0", bus.pmem_read, bus.pmem_write);
    end
  endtask

  task automatic test_icache_only();
    logic [LW-1:0] a5 = {32{8'hA5}};
    @(negedge clk);
    bus.i_pmem_read    = 1'b1;
    bus.i_pmem_address = 32'h0000_1000;
    #1;
    checks++;
    if (bus.pmem_read !== 1'b0) begin
      failures++;
      $display("FAIL i_only_bubble got pmem_read=%b want 0", bus.pmem_read);
    end
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      bus.pmem_resp  = (k == 5);
      bus.pmem_rdata = (k == 5) ? a5 : rand_line();
      #1;
      checks++;
      if (bus.pmem_read !== 1'b1 || bus.pmem_address !== 32'h0000_1000) begin
        failures++;
        $display("FAIL i_only_req cyc%0d got r=%b a=%h want 1 00001000", k, bus.pmem_read, bus.pmem_address);
      end
      checks++;
      if (bus.i_pmem_resp !== (k == 5) || bus.d_pmem_resp !== 1'b0) begin
        failures++;
        $display("FAIL i_only_resp cyc%0d got i=%b d=%b want %b 0", k, bus.i_pmem_resp, bus.d_pmem_resp, (k == 5));
      end
      checks++;
      if (bus.i_pmem_rdata !== bus.pmem_rdata || bus.d_pmem_rdata !== '0) begin
        failures++;
        $display("FAIL i_only_rdata cyc%0d got %h", k, bus.i_pmem_rdata);
      end
    end
    @(negedge clk);
    idle_inputs();
    #1;
    checks++;
    if (bus.pmem_read !== 1'b0 || bus.i_pmem_resp !== 1'b0) begin
      failures++;
      $display("FAIL i_only_idle got r=%b resp=%b want 0 0", bus.pmem_read, bus.i_pmem_resp);
    end
  endtask

  task automatic test_both_same_cycle();
    logic [LW-1:0] r1 = rand_line();
    logic [LW-1:0] r2 = rand_line();
    @(negedge clk);
    bus.i_pmem_read = 1'b1; bus.i_pmem_address = 32'h2000;
    bus.d_pmem_read = 1'b1; bus.d_pmem_address = 32'h3000;
    @(negedge clk);
    #1;
    checks++;
    if (bus.pmem_read !== 1'b1 || bus.pmem_address !== 32'h3000) begin
      failures++;
      $display("FAIL both_d_first got r=%b a=%h want 1 00003000", bus.pmem_read, bus.pmem_address);
    end
    @(negedge clk);
    bus.pmem_resp = 1'b1; bus.pmem_rdata = r1;
    #1;
    checks++;
    if (bus.d_pmem_resp !== 1'b1 || bus.i_pmem_resp !== 1'b0 || bus.d_pmem_rdata !== r1 || bus.i_pmem_rdata !== '0) begin
      failures++;
      $display("FAIL both_d_resp got d=%b i=%b want 1 0", bus.d_pmem_resp, bus.i_pmem_resp);
    end
    @(negedge clk);
    bus.pmem_resp = 1'b0; bus.d_pmem_read = 1'b0;
    #1;
    checks++;
    if (bus.pmem_read !== 1'b0) begin
      failures++;
      $display("FAIL both_gap got pmem_read=%b want 0", bus.pmem_read);
    end
    @(negedge clk);
    #1;
    checks++;
    if (bus.pmem_read !== 1'b1 || bus.pmem_address !== 32'h2000) begin
      failures++;
      $display("FAIL both_i_second got r=%b a=%h want 1 00002000", bus.pmem_read, bus.pmem_address);
    end
    @(negedge clk);
    bus.pmem_resp = 1'b1; bus.pmem_rdata = r2;
    #1;
    checks++;
    if (bus.i_pmem_resp !== 1'b1 || bus.d_pmem_resp !== 1'b0 || bus.i_pmem_rdata !== r2 || bus.d_pmem_rdata !== '0) begin
      failures++;
      $display("FAIL both_i_resp got i=%b d=%b want 1 0", bus.i_pmem_resp, bus.d_pmem_resp);
    end
    @(negedge clk);
    idle_inputs();
  endtask

  task automatic test_writeback_then_fill();
    logic [LW-1:0] w = rand_line();
    logic [LW-1:0] r = rand_line();
    @(negedge clk);
    bus.d_pmem_write = 1'b1; bus.d_pmem_address = 32'h8000; bus.d_pmem_wdata = w;
    @(negedge clk);
    #1;
    checks++;
    if (bus.pmem_write !== 1'b1 || bus.pmem_read !== 1'b0 || bus.pmem_address !== 32'h8000 || bus.pmem_wdata !== w) begin
      failures++;
      $display("FAIL wb_req got w=%b r=%b a=%h wd=%h", bus.pmem_write, bus.pmem_read, bus.pmem_address, bus.pmem_wdata);
    end
    @(negedge clk);
    bus.pmem_resp = 1'b1;
    #1;
    checks++;
    if (bus.d_pmem_resp !== 1'b1 || bus.i_pmem_resp !== 1'b0) begin
      failures++;
      $display("FAIL wb_resp got d=%b i=%b want 1 0", bus.d_pmem_resp, bus.i_pmem_resp);
    end
    @(negedge clk);
    bus.pmem_resp = 1'b0;
    bus.d_pmem_write = 1'b0; bus.d_pmem_read = 1'b1; bus.d_pmem_address = 32'h4000;
    #1;
    checks++;
    if (bus.pmem_read !== 1'b0 || bus.pmem_write !== 1'b0 || bus.d_pmem_resp !== 1'b0) begin
      failures++;
      $display("FAIL wb_gap got r=%b w=%b resp=%b want 0 0 0", bus.pmem_read, bus.pmem_write, bus.d_pmem_resp);
    end
    @(negedge clk);
    #1;
    checks++;
    if (bus.pmem_read !== 1'b1 || bus.pmem_write !== 1'b0 || bus.pmem_address !== 32'h4000) begin
      failures++;
      $display("FAIL fill_req got r=%b w=%b a=%h want 1 0 00004000", bus.pmem_read, bus.pmem_write, bus.pmem_address);
    end
    @(negedge clk);
    bus.pmem_resp = 1'b1; bus.pmem_rdata = r;
    #1;
    checks++;
    if (bus.d_pmem_resp !== 1'b1 || bus.d_pmem_rdata !== r) begin
      failures++;
      $display("FAIL fill_resp got resp=%b rdata=%h", bus.d_pmem_resp, bus.d_pmem_rdata);
    end
    @(negedge clk);
    idle_inputs();
  endtask

  task automatic test_reset_mid_transaction();
    @(negedge clk);
    bus.d_pmem_read = 1'b1; bus.d_pmem_address = 32'h7000;
    bus.pmem_rdata  = rand_line();
    @(negedge clk);
    #1;
    checks++;
    if (bus.pmem_read !== 1'b1) begin
      failures++;
      $display("FAIL mid_rst_serving got pmem_read=%b want 1", bus.pmem_read);
    end
    @(negedge clk);
    #1;
    rst = 1'b0;
    bus.pmem_resp = 1'b1;
    #1;
    checks++;
    if (out_ones() !== 0) begin
      failures++;
      $display("FAIL mid_rst_outputs got %0d set bits, want 0", out_ones());
    end
    @(negedge clk);
    idle_inputs();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    bus.i_pmem_read = 1'b1; bus.i_pmem_address = 32'h9000;
    @(negedge clk);
    #1;
    checks++;
    if (bus.pmem_read !== 1'b1 || bus.pmem_address !== 32'h9000) begin
      failures++;
      $display("FAIL mid_rst_regrant got r=%b a=%h want 1 00009000", bus.pmem_read, bus.pmem_address);
    end
    @(negedge clk);
    bus.pmem_resp = 1'b1;
    #1;
    checks++;
    if (bus.i_pmem_resp !== 1'b1 || bus.d_pmem_resp !== 1'b0) begin
      failures++;
      $display("FAIL mid_rst_resp got i=%b d=%b want 1 0", bus.i_pmem_resp, bus.d_pmem_resp);
    end
    @(negedge clk);
    idle_inputs();
  endtask

  task automatic test_grant_order();
`ifdef PMEM_ARB_ROUND_ROBIN_EN
    string exp_s = "DIDI";
`else
    string exp_s = "DDID";
`endif
    string got_s = "";
    @(negedge clk);
    bus.i_pmem_read = 1'b1; bus.i_pmem_address = 32'h5000;
    bus.d_pmem_read = 1'b1; bus.d_pmem_address = 32'h6000;
    for (int c = 0; c < 40 && got_s.len() < 4; c++) begin
      @(negedge clk);
      #1;
      bus.pmem_resp = bus.pmem_read | bus.pmem_write;
      #1;
      if (bus.d_pmem_resp) got_s = {got_s, "D"};
      else if (bus.i_pmem_resp) got_s = {got_s, "I"};
    end
    @(negedge clk);
    idle_inputs();
    checks++;
    if (got_s != exp_s) begin
      failures++;
      $display("FAIL grant_order got %s want %s", got_s, exp_s);
    end
  endtask

  task automatic test_random();
    int m_owner = 0;
    int m_streak = 0;
    int m_last = 1;
    int mem_cnt = 0;
    int mem_lat = 2;
    int win;
    int i_txn = 0, d_txn = 0;
    bit i_done = 0, d_done = 0, stop, iq, dq, w;
    logic exp_pr, exp_pw, exp_ir, exp_dr;
    logic [AW-1:0] exp_addr;
    logic [LW-1:0] exp_wd, exp_irdata, exp_drdata;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    for (int c = 0; c < 1600; c++) begin
      @(negedge clk);
      stop = (c >= 1550);
      if (!bus.i_pmem_read || i_done) begin
        i_done = 0;
        if (!stop && $urandom_range(0, 99) < 40) begin
          bus.i_pmem_read = 1'b1;
          bus.i_pmem_address = $urandom & ~32'h1F;
        end else bus.i_pmem_read = 1'b0;
      end
      if (!(bus.d_pmem_read || bus.d_pmem_write) || d_done) begin
        d_done = 0;
        if (!stop && $urandom_range(0, 99) < 50) begin
          w = $urandom_range(0, 1);
          bus.d_pmem_write = w;
          bus.d_pmem_read = !w;
          bus.d_pmem_address = $urandom & ~32'h1F;
          bus.d_pmem_wdata = rand_line();
        end else begin
          bus.d_pmem_write = 1'b0;
          bus.d_pmem_read = 1'b0;
        end
      end
      bus.pmem_rdata = rand_line();
      #1;
      if (bus.pmem_read || bus.pmem_write) begin
        mem_cnt++;
        if (mem_cnt >= mem_lat) begin
          bus.pmem_resp = 1'b1;
          mem_cnt = 0;
          mem_lat = $urandom_range(1, 4);
        end else bus.pmem_resp = 1'b0;
      end else bus.pmem_resp = ($urandom_range(0, 9) == 0);
      #1;
      exp_pr = 0; exp_pw = 0; exp_ir = 0; exp_dr = 0;
      exp_addr = '0; exp_wd = '0; exp_irdata = '0; exp_drdata = '0;
      if (m_owner == 1) begin
        exp_pr = bus.i_pmem_read;
        exp_addr = bus.i_pmem_address;
        exp_ir = bus.pmem_resp;
        exp_irdata = bus.pmem_rdata;
      end else if (m_owner == 2) begin
        exp_pr = bus.d_pmem_read && !bus.d_pmem_write;
        exp_pw = bus.d_pmem_write;
        exp_addr = bus.d_pmem_address;
        exp_wd = bus.d_pmem_wdata;
        exp_dr = bus.pmem_resp;
        exp_drdata = bus.pmem_rdata;
      end
      checks++;
      if (bus.pmem_read !== exp_pr || bus.pmem_write !== exp_pw) begin
        failures++;
        $display("FAIL rand_rw cyc%0d got r=%b w=%b want %b %b", c, bus.pmem_read, bus.pmem_write, exp_pr, exp_pw);
      end
      checks++;
      if (bus.pmem_address !== exp_addr) begin
        failures++;
        $display("FAIL rand_addr cyc%0d got %h want %h", c, bus.pmem_address, exp_addr);
      end
      checks++;
      if (bus.pmem_wdata !== exp_wd) begin
        failures++;
        $display("FAIL rand_wdata cyc%0d got %h want %h", c, bus.pmem_wdata, exp_wd);
      end
      checks++;
      if (bus.i_pmem_resp !== exp_ir || bus.d_pmem_resp !== exp_dr) begin
        failures++;
        $display("FAIL rand_resp cyc%0d got i=%b d=%b want %b %b", c, bus.i_pmem_resp, bus.d_pmem_resp, exp_ir, exp_dr);
      end
      checks++;
      if (bus.i_pmem_rdata !== exp_irdata) begin
        failures++;
        $display("FAIL rand_irdata cyc%0d got %h want %h", c, bus.i_pmem_rdata, exp_irdata);
      end
      checks++;
      if (bus.d_pmem_rdata !== exp_drdata) begin
        failures++;
        $display("FAIL rand_drdata cyc%0d got %h want %h", c, bus.d_pmem_rdata, exp_drdata);
      end
      checks++;
      if (arb_error !== 1'b0) begin
        failures++;
        $display("FAIL rand_arb_error cyc%0d got %b want 0", c, arb_error);
      end
      if (bus.i_pmem_resp) begin i_done = 1; i_txn++; end
      if (bus.d_pmem_resp) begin d_done = 1; d_txn++; end
      // Grant model: one owner until its resp, then a decision from the pending requests.
      if (m_owner != 0) begin
        if (bus.pmem_resp) m_owner = 0;
      end else begin
        iq = bus.i_pmem_read;
        dq = bus.d_pmem_read || bus.d_pmem_write;
        win = 0;
        if (iq && dq) begin
`ifdef PMEM_ARB_ROUND_ROBIN_EN
          win = (m_last == 2) ? 1 : 2;
`else
          win = (m_streak >= MAX_D) ? 1 : 2;
`endif
        end else if (dq) win = 2;
        else if (iq) win = 1;
        if (win == 2 && iq) m_streak = (m_streak < MAX_D) ? m_streak + 1 : MAX_D;
        if (win == 1) m_streak = 0;
        if (win != 0) m_last = win;
        m_owner = win;
      end
    end
    @(negedge clk);
    idle_inputs();
    #1;
    checks++;
    if (m_owner != 0 || bus.pmem_read !== 1'b0 || bus.pmem_write !== 1'b0 || i_txn < 20 || d_txn < 20) begin
      failures++;
      $display("FAIL rand_drain got owner=%0d r=%b w=%b i_txn=%0d d_txn=%0d", m_owner, bus.pmem_read, bus.pmem_write, i_txn, d_txn);
    end
  endtask

  task automatic test_arb_error();
    @(negedge clk);
    bus.d_pmem_read = 1'b1; bus.d_pmem_write = 1'b1;
    bus.d_pmem_address = 32'hA000; bus.d_pmem_wdata = rand_line();
    #1;
    checks++;
    if (arb_error !== 1'b0) begin
      failures++;
      $display("FAIL err_before got %b want 0", arb_error);
    end
    @(negedge clk);
    #1;
    checks++;
    if (bus.pmem_write !== 1'b1 || bus.pmem_read !== 1'b0 || bus.pmem_wdata !== bus.d_pmem_wdata) begin
      failures++;
      $display("FAIL err_write_wins got w=%b r=%b want 1 0", bus.pmem_write, bus.pmem_read);
    end
    @(negedge clk);
    bus.pmem_resp = 1'b1;
    #1;
    checks++;
    if (arb_error !== 1'b1 || bus.d_pmem_resp !== 1'b1) begin
      failures++;
      $display("FAIL err_set got err=%b resp=%b want 1 1", arb_error, bus.d_pmem_resp);
    end
    @(negedge clk);
    idle_inputs();
    @(negedge clk);
    #1;
    checks++;
    if (arb_error !== 1'b1) begin
      failures++;
      $display("FAIL err_sticky got %b want 1", arb_error);
    end
    @(negedge clk);
    rst = 1'b0;
    #1;
    checks++;
    if (arb_error !== 1'b0) begin
      failures++;
      $display("FAIL err_reset_clear got %b want 0", arb_error);
    end
    @(negedge clk);
    rst = 1'b1;
  endtask

  initial begin
    test_reset();
    test_icache_only();
    test_both_same_cycle();
    test_writeback_then_fill();
    test_reset_mid_transaction();
    test_grant_order();
    test_random();
    test_arb_error();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/pmem_arbiter.md
Name: pmem_arbiter

Overview:
- Arbitrates a single physical-memory port (the cacheline adaptor) between the icache and the dcache miss/writeback interfaces.
- Sits between both cache controllers' pmem_* ports and the one downstream line-wide memory port.
- Owns the request/response sequencing: one outstanding transaction at a time, the response is routed to its owner only, and dcache priority is bounded by a starvation limit.

Parameters:
- ADDR_WIDTH, 32, byte address width.
- LINE_WIDTH, 256, cacheline data width.
- MAX_D_STREAK, 4, max consecutive dcache grants while the icache is waiting; must be at least 1.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous, active-low reset.
- i_pmem_read  in  1  icache line-fill request.
- i_pmem_address  in  ADDR_WIDTH  icache line address.
- i_pmem_rdata  out  LINE_WIDTH  line data to icache.
- i_pmem_resp  out  1  icache transaction done.
- d_pmem_read  in  1  dcache line-fill request.
- d_pmem_write  in  1  dcache writeback request.
- d_pmem_address  in  ADDR_WIDTH  dcache line address.
- d_pmem_wdata  in  LINE_WIDTH  dcache writeback data.
- d_pmem_rdata  out  LINE_WIDTH  line data to dcache.
- d_pmem_resp  out  1  dcache transaction done.
- pmem_read  out  1  downstream read.
- pmem_write  out  1  downstream write.
- pmem_address  out  ADDR_WIDTH  downstream address.
- pmem_wdata  out  LINE_WIDTH  downstream write data.
- pmem_rdata  in  LINE_WIDTH  downstream read data.
- pmem_resp  in  1  downstream done; one-cycle pulse.
- arb_error  out  1  sticky flag: d_pmem_read and d_pmem_write asserted together.

Behaviour:
- Requesters hold their request and operands stable until they see their resp.
- State machine states:
  - IDLE: no downstream request.
  - SERVE_I: icache owns the port.
  - SERVE_D: dcache owns the port.
- Reset (rst low, asynchronous):
  - state goes to IDLE; the d_streak counter and arb_error clear.
  - All outputs are 0: pmem_read, pmem_write, pmem_address, pmem_wdata, both resps, both rdata buses.
  - Reset asserted mid-transaction abandons it; no resp is issued.
- IDLE decision, registered into the next state:
  - No request: stay in IDLE.
  - Only icache requesting: go to SERVE_I.
  - Only dcache requesting (read or write): go to SERVE_D.
  - Both requesting: go to SERVE_D, unless d_streak == MAX_D_STREAK, in which case go to SERVE_I.
- Latency: a request seen in IDLE at edge N drives downstream from cycle N+1. Minimum one-cycle arbitration bubble.
- SERVE_I outputs:
  - pmem_read = i_pmem_read; pmem_write = 0.
  - pmem_address = i_pmem_address; pmem_wdata = 0.
- SERVE_D outputs:
  - pmem_read = d_pmem_read and not d_pmem_write; pmem_write = d_pmem_write (write wins on conflict).
  - pmem_address = d_pmem_address; pmem_wdata = d_pmem_wdata.
- Response routing:
  - In SERVE_x, when pmem_resp=1, x_pmem_resp=1 combinationally in the same cycle, and the next state is IDLE.
  - The non-owner resp is always 0.
  - pmem_resp in IDLE is ignored.
- rdata: pmem_rdata is forwarded to the owner's rdata bus in SERVE_x. The non-owner's rdata bus and both buses in IDLE are 0.
- Mandatory IDLE after each resp: gives the cache one cycle to drop or change its request. A dcache writeback followed by a fill is therefore two separate grants.
- d_streak counter, width clog2(MAX_D_STREAK+1):
  - At a SERVE_D grant with i_pmem_read=1: increments, saturating at MAX_D_STREAK.
  - At a SERVE_I grant: clears.
  - At a SERVE_D grant with no icache request pending: unchanged.
- Owner dropping its request before resp: downstream requests deassert, and the state holds until pmem_resp. Such a drop is a protocol violation.
- arb_error:
  - Sets when d_pmem_read and d_pmem_write are both 1 in SERVE_D.
  - Clears only on reset.

Optional Feature:
- Macro: PMEM_ARB_ROUND_ROBIN_EN.
- Defined:
  - On simultaneous requests, the grant goes to the requester not served last. A last_grant flop resets to "icache", so dcache wins the first tie.
  - d_streak logic and MAX_D_STREAK are unused.
- Undefined: dcache-priority arbitration with the starvation limit, as above.

Test Plan:
- Icache-only read, address 0x0000_1000, memory returns resp on cycle 5 with rdata 0xA5..A5 -> pmem_read=1 from cycle 1; i_pmem_resp=1 only on cycle 5 with i_pmem_rdata=0xA5..A5; d_pmem_resp=0 throughout; IDLE on cycle 6.
- Icache and dcache reads both raised in the same cycle -> dcache served first, pmem_address = d addr; after its resp, one IDLE cycle; then SERVE_I.
- Dcache writeback to 0x8000 followed by a fill from 0x4000 -> pmem_write with wdata passed through; d_pmem_resp; IDLE; pmem_read at 0x4000; two distinct resps.
- MAX_D_STREAK=2, dcache requesting continuously, icache held -> grant order D, D, I, D.
- rst pulled low during SERVE_D before resp -> all outputs 0 immediately; after release, a new icache request is granted normally.
- PMEM_ARB_ROUND_ROBIN_EN defined, both requesting continuously -> grant order D, I, D, I.
